// File: rtl/async_fifo_wr_front.sv
// Write-domain front end of the asynchronous FIFO.
// Buffers an upstream valid/ready stream in a 2-entry skid buffer, issues
// winc/wdata toward the pointer block and memory, synchronizes the Gray read
// pointer into wclk, and reports a registered fill level and almost-full flag.
module async_fifo_wr_front #(
    parameter int DATASIZE     = 8,
    parameter int ADDRSIZE     = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [DATASIZE-1:0] s_data,
    input  logic [ADDRSIZE:0]   rptr,
    input  logic [ADDRSIZE:0]   wptr,
    input  logic                wfull,
    output logic                winc,
    output logic [DATASIZE-1:0] wdata,
    output logic [ADDRSIZE:0]   wq2_rptr,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                walmost_full
);

    localparam int               PTR_W     = ADDRSIZE + 1;
    localparam logic [PTR_W-1:0] AFULL_LVL = PTR_W'(AFULL_THRESH);

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
        logic [PTR_W-1:0] b;
        b[PTR_W-1] = g[PTR_W-1];
        for (int i = PTR_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // ------------------------------------------------------------------
    // Read-pointer synchronizer
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] r_wq1_rptr;
    logic [PTR_W-1:0] r_wq2_rptr;

    // Two-flop synchronizer for the Gray read pointer crossing into wclk.
    // NOTE: rptr feeds the first flop directly; any logic in front of it could
    // combine bits from different read-domain updates and break the Gray
    // single-bit-change guarantee. Sequential state always uses <= so every
    // flop samples the pre-edge value of its neighbours.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_wq1_rptr <= '0;
            r_wq2_rptr <= '0;
        end else begin
            r_wq1_rptr <= rptr;
            r_wq2_rptr <= r_wq1_rptr;
        end
    end

    assign wq2_rptr = r_wq2_rptr;

    // ------------------------------------------------------------------
    // Fill level and almost-full
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] w_wbin;
    logic [PTR_W-1:0] w_rbin;
    logic [PTR_W-1:0] w_level_next;
    logic [PTR_W-1:0] r_wlevel;
    logic             r_walmost_full;

    assign w_wbin       = gray2bin(wptr);
    assign w_rbin       = gray2bin(r_wq2_rptr);
    // Natural PTR_W-bit wrap gives the modulo-2^(ADDRSIZE+1) difference.
    assign w_level_next = w_wbin - w_rbin;

    // Register level and almost-full from the same next value so they move together.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_wlevel       <= '0;
            r_walmost_full <= 1'b0;
        end else begin
            r_wlevel       <= w_level_next;
            r_walmost_full <= (w_level_next >= AFULL_LVL);
        end
    end

    assign wlevel       = r_wlevel;
    assign walmost_full = r_walmost_full;

    // ------------------------------------------------------------------
    // 2-entry skid buffer (entry0 is the head)
    // ------------------------------------------------------------------
    logic [1:0]          r_count;
    logic [DATASIZE-1:0] r_entry0;
    logic [DATASIZE-1:0] r_entry1;
    logic                r_s_ready;

    logic                w_push;
    logic                w_pop;
    logic [1:0]          w_count_next;
    logic [DATASIZE-1:0] w_entry0_next;
    logic [DATASIZE-1:0] w_entry1_next;

    assign w_push = s_valid & r_s_ready;
    // Never request a write while the pointer block reports full.
    assign w_pop  = (r_count != 2'd0) & ~wfull;

    // Next skid contents for push, pop, or both; order is always preserved.
    // NOTE: every output is given its hold value first, so no path through
    // the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_count_next  = r_count;
        w_entry0_next = r_entry0;
        w_entry1_next = r_entry1;
        case ({w_push, w_pop})
            2'b10: begin
                if (r_count == 2'd0) begin
                    w_entry0_next = s_data;
                end else begin
                    w_entry1_next = s_data;
                end
                w_count_next = r_count + 2'd1;
            end
            2'b01: begin
                w_entry0_next = r_entry1;
                w_count_next  = r_count - 2'd1;
            end
            2'b11: begin
                // Head leaves; the new word lands behind whatever remains.
                if (r_count == 2'd1) begin
                    w_entry0_next = s_data;
                end else begin
                    w_entry0_next = r_entry1;
                    w_entry1_next = s_data;
                end
            end
            default: ;
        endcase
    end

    // Skid state and registered ready; ready looks ahead at the next count.
    // NOTE: the two data entries are reset as well so wdata is a defined zero
    // after reset and no stale word can reach the memory port.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_count   <= 2'd0;
            r_entry0  <= '0;
            r_entry1  <= '0;
            r_s_ready <= 1'b0;
        end else begin
            r_count   <= w_count_next;
            r_entry0  <= w_entry0_next;
            r_entry1  <= w_entry1_next;
            r_s_ready <= (w_count_next < 2'd2);
        end
    end

    assign s_ready = r_s_ready;
    assign winc    = w_pop;
    assign wdata   = r_entry0;

endmodule
